// File: rtl/fazyrv_ccx_alu.sv
// fazyrv_ccx_alu: chunk-serial ALU (AND/XOR/ADD/ROL) on the FazyRV CCX port
module fazyrv_ccx_alu #(
  parameter int CHUNKSIZE = 8,
  parameter int LATENCY   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  input  logic [1:0]           ccx_sel_i,
  input  logic                 ccx_req_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o,
  output logic                 busy_o
);
  localparam int N  = 32 / CHUNKSIZE;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, SEND} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] lat;
  logic [31:0] a, b, res, alu;
  logic [63:0] rot;
  logic [1:0] sel;
  logic take, last_lat;
  always_comb begin
    take = (state == IDLE && ccx_req_i) || state == COLLECT;
    last_lat = lat == 4'(LATENCY - 1);
    rot = {a, a} << b[4:0];
    alu = sel == 2'b00 ? a & b : sel == 2'b01 ? a ^ b : sel == 2'b10 ? a + b : rot[63:32];
    state_n = state;
    case (state)
      IDLE:    state_n = ccx_req_i ? COLLECT : IDLE;
      COLLECT: state_n = cnt == CW'(N - 2) ? COMPUTE : COLLECT;
      COMPUTE: state_n = last_lat ? SEND : COMPUTE;
      SEND:    state_n = cnt == CW'(N - 1) ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
    ccx_res_o = state == SEND ? res[CHUNKSIZE-1:0] : '0;
    ccx_resp_o = state == SEND && cnt == '0;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else state <= state_n;
  end
  // operands fill from the top so chunk 0 lands at the LSB after N captures
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      a <= '0;
      b <= '0;
      res <= '0;
      sel <= '0;
      cnt <= '0;
      lat <= '0;
    end else begin
      if (take) begin
        a <= {ccx_rs_a_i, a[31:CHUNKSIZE]};
        b <= {ccx_rs_b_i, b[31:CHUNKSIZE]};
      end
      if (state == IDLE && ccx_req_i) sel <= ccx_sel_i;
      if (state == COMPUTE && last_lat) res <= alu;
      else if (state == SEND) res <= res >> CHUNKSIZE;
      cnt <= ((state == COLLECT || state == SEND) && state_n == state) ? cnt + 1'b1 : '0;
      lat <= (state == COMPUTE && state_n == COMPUTE) ? lat + 4'd1 : '0;
    end
  end
endmodule

// File: tb/tb_fazyrv_ccx_alu.sv
// tb_fazyrv_ccx_alu: directed and random operations checked against a behavioural model
module tb_fazyrv_ccx_alu;
  localparam int CS = 4, L = 2, N = 8;
  logic clk_i = 0, rst_in = 0;
  logic [CS-1:0] ccx_rs_a_i = 0, ccx_rs_b_i = 0;
  logic [1:0] ccx_sel_i = 0;
  logic ccx_req_i = 0;
  logic [CS-1:0] ccx_res_o;
  logic ccx_resp_o, busy_o;
  int checks = 0, fails = 0;
  logic [31:0] got, got2;

  fazyrv_ccx_alu #(.CHUNKSIZE(CS), .LATENCY(L)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .ccx_rs_a_i(ccx_rs_a_i), .ccx_rs_b_i(ccx_rs_b_i),
    .ccx_sel_i(ccx_sel_i), .ccx_req_i(ccx_req_i), .ccx_res_o(ccx_res_o),
    .ccx_resp_o(ccx_resp_o), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model(logic [1:0] s, logic [31:0] x, logic [31:0] y);
    logic [31:0] r;
    r = x;
    case (s)
      2'd0: r = x & y;
      2'd1: r = x ^ y;
      2'd2: r = x + y;
      default: repeat (int'(y % 32)) r = {r[30:0], r[31]};
    endcase
    return r;
  endfunction

  task automatic chk(string tag, int c, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      ccx_req_i = 0;
      ccx_sel_i = 2'($urandom);
      ccx_rs_a_i = 4'($urandom);
      ccx_rs_b_i = 4'($urandom);
      chk("idle_res", c, 32'(ccx_res_o), 0);
      chk("idle_resp", c, 32'(ccx_resp_o), 0);
      chk("idle_busy", c, 32'(busy_o), 0);
    end
  endtask

  // cycle c of the loop is cycle T+c relative to the request
  task automatic run_op(logic [1:0] s, logic [31:0] x, logic [31:0] y, int sp1, int sp2,
                        int abort, output logic [31:0] res);
    logic [31:0] e;
    e = model(s, x, y);
    res = 0;
    for (int c = 0; c < 2 * N + L; c++) begin
      @(negedge clk_i);
      ccx_req_i = c == 0 || c == sp1 || c == sp2;
      ccx_sel_i = c == 0 ? s : 2'($urandom);
      ccx_rs_a_i = c < N ? 4'(x >> (4 * c)) : 4'($urandom);
      ccx_rs_b_i = c < N ? 4'(y >> (4 * c)) : 4'($urandom);
      if (c == abort) begin
        rst_in = 0;
        ccx_req_i = 0;
        #1;
        chk("rst_res", c, 32'(ccx_res_o), 0);
        chk("rst_resp", c, 32'(ccx_resp_o), 0);
        chk("rst_busy", c, 32'(busy_o), 0);
        @(negedge clk_i);
        rst_in = 1;
        return;
      end
      chk("res", c, 32'(ccx_res_o), c >= N + L ? 32'(4'(e >> (4 * (c - N - L)))) : 0);
      chk("resp", c, 32'(ccx_resp_o), 32'(c == N + L));
      chk("busy", c, 32'(busy_o), 32'(c != 0));
      if (c >= N + L) res[4 * (c - N - L) +: 4] = ccx_res_o;
    end
  endtask

  initial begin
    #1;
    chk("reset_res", 0, 32'(ccx_res_o), 0);
    chk("reset_resp", 0, 32'(ccx_resp_o), 0);
    chk("reset_busy", 0, 32'(busy_o), 0);
    repeat (2) @(negedge clk_i);
    rst_in = 1;
    idle(2);
    run_op(2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, -1, -1, -1, got);
    chk("and", 0, got, 32'h00F0_1234);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0001, -1, -1, -1, got);
    chk("add_wrap", 0, got, 32'h0000_0000);
    idle(3);
    run_op(2'b11, 32'h8000_0001, 32'hFFFF_FFE4, -1, -1, -1, got);
    chk("rotate", 0, got, 32'h0000_0018);
    idle(1);
    run_op(2'b01, 32'hAAAA_5555, 32'hFFFF_0000, -1, -1, -1, got);
    run_op(2'b10, 32'h1234_5678, 32'h0FED_CBA9, -1, -1, -1, got2);
    chk("b2b_xor", 0, got, 32'h5555_5555);
    chk("b2b_add", 0, got2, 32'h2222_2221);
    run_op(2'b01, 32'hAAAA_5555, 32'hFFFF_0000, 3, 12, -1, got);
    chk("spurious", 0, got, 32'h5555_5555);
    run_op(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, -1, -1, 11, got);
    idle(2);
    run_op(2'b11, 32'h1234_5678, 32'h0000_0008, -1, -1, -1, got);
    chk("after_reset", 0, got, 32'h3456_7812);
    for (int i = 0; i < 30; i++) begin
      logic [1:0] s;
      logic [31:0] x, y;
      s = 2'($urandom);
      x = $urandom;
      y = $urandom;
      run_op(s, x, y, int'($urandom_range(1, 2 * N + L + 4)), int'($urandom_range(1, 2 * N + L + 4)), -1, got);
      chk("random", i, got, model(s, x, y));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
